// File: rtl/mdu_unit_pkg.sv
// Shared constants for the RV32M multiply/divide unit: widths, funct3
// encodings, FSM states and the iteration count.
package mdu_unit_pkg;

    localparam int ZCRV_XLEN     = 32;
    localparam int ZCRV_REG_SIZE = 5;

    localparam logic [2:0] ZCRV_MDU_MUL    = 3'd0;
    localparam logic [2:0] ZCRV_MDU_MULH   = 3'd1;
    localparam logic [2:0] ZCRV_MDU_MULHSU = 3'd2;
    localparam logic [2:0] ZCRV_MDU_MULHU  = 3'd3;
    localparam logic [2:0] ZCRV_MDU_DIV    = 3'd4;
    localparam logic [2:0] ZCRV_MDU_DIVU   = 3'd5;
    localparam logic [2:0] ZCRV_MDU_REM    = 3'd6;
    localparam logic [2:0] ZCRV_MDU_REMU   = 3'd7;

    localparam int         MDU_ITER      = 32;
    localparam logic [5:0] MDU_ITER_LAST = 6'(MDU_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Shared 2*W-bit shift register with one (W+1)-bit adder: one shift-add
// multiply step or one restoring-divide step per cycle.
module mdu_iter_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           is_div_i,
    input  logic [W-1:0]   lo_i,
    input  logic [W-1:0]   opnd_i,
    output logic [2*W-1:0] acc_o
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opnd_q;
    logic [W:0]     partial;
    logic [W:0]     addend;
    logic [W:0]     sum;
    logic           ge;

    // Divide works on the remainder shifted left by one, hence W+1 bits.
    assign partial = acc_q[2*W-1:W-1];
    assign addend  = is_div_i ? partial : {1'b0, acc_q[2*W-1:W]};
    assign sum     = is_div_i ? addend - {1'b0, opnd_q}
                              : addend + {1'b0, opnd_q};
    assign ge      = partial >= {1'b0, opnd_q};

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = {{W{1'b0}}, lo_i};
        end else if (step_i) begin
            if (is_div_i) begin
                acc_d = ge ? {sum[W-1:0], acc_q[W-2:0], 1'b1}
                           : {acc_q[2*W-2:0], 1'b0};
            end else begin
                acc_d = acc_q[0] ? {sum, acc_q[W-1:1]}
                                 : {1'b0, acc_q[2*W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opnd_q <= opnd_i;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mdu_unit.sv
// Iterative RV32M multiply/divide unit feeding write-back.
// Define ZCRV_MDU_FAST_MUL_EN for single-cycle multiplies.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int XLEN     = ZCRV_XLEN,
    parameter int REG_SIZE = ZCRV_REG_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_from_flushunit,
    input  logic                mdu_start_from_idex,
    input  logic [2:0]          mdu_op_from_idex,
    input  logic [XLEN-1:0]     rs1_data_from_idex,
    input  logic [XLEN-1:0]     rs2_data_from_idex,
    input  logic [REG_SIZE-1:0] rd_from_idex,
    output logic                mdu_busy,
    output logic                mdu_finish,
    output logic [XLEN-1:0]     mdu_result,
    output logic [REG_SIZE-1:0] mdu_now_rd
);

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [REG_SIZE-1:0] rd_q, rd_d;
    logic                neg1_q, neg1_d;
    logic                neg2_q, neg2_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic [2:0]          op;
    logic [XLEN-1:0]     rs1, rs2;
    logic                sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                accept, is_div, div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;
    logic [2*XLEN-1:0]   acc, prod;
    logic [XLEN-1:0]     quo, rem, fix_res;

    assign op  = mdu_op_from_idex;
    assign rs1 = rs1_data_from_idex;
    assign rs2 = rs2_data_from_idex;

    assign sgn1 = (op == ZCRV_MDU_MULH) || (op == ZCRV_MDU_MULHSU)
               || (op == ZCRV_MDU_DIV)  || (op == ZCRV_MDU_REM);
    assign sgn2 = (op == ZCRV_MDU_MULH) || (op == ZCRV_MDU_DIV)
               || (op == ZCRV_MDU_REM);
    assign neg1 = sgn1 & rs1[XLEN-1];
    assign neg2 = sgn2 & rs2[XLEN-1];
    assign mag1 = neg1 ? -rs1 : rs1;
    assign mag2 = neg2 ? -rs2 : rs2;

    assign accept   = (state_q == S_IDLE) & mdu_start_from_idex
                    & ~flush_from_flushunit;
    assign is_div   = op[2];
    assign div_zero = (rs2 == '0);
    assign div_ovf  = sgn2 & (rs1 == MIN_INT) & (rs2 == '1);
    assign special  = is_div & (div_zero | div_ovf);
    // op[1] selects the remainder flavour of a divide.
    assign special_res = div_zero ? (op[1] ? rs1 : '1)
                                  : (op[1] ? '0 : MIN_INT);

`ifdef ZCRV_MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fp;
    logic [XLEN-1:0]          fast_res;

    assign fa = {sgn1 & rs1[XLEN-1], rs1};
    assign fb = {sgn2 & rs2[XLEN-1], rs2};
    assign fp = fa * fb;
    assign fast_res = (op == ZCRV_MDU_MUL) ? fp[XLEN-1:0]
                                           : fp[2*XLEN-1:XLEN];
`endif

    mdu_iter_core #(.W(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .step_i   (state_q == S_CALC),
        .is_div_i (op_q[2]),
        .lo_i     (is_div ? mag1 : mag2),
        .opnd_i   (is_div ? mag2 : mag1),
        .acc_o    (acc)
    );

    assign prod    = (neg1_q ^ neg2_q) ? -acc : acc;
    assign quo     = (neg1_q ^ neg2_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem     = neg1_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_res = op_q[2] ? (op_q[1] ? rem : quo)
                   : ((op_q == ZCRV_MDU_MUL) ? prod[XLEN-1:0]
                                             : prod[2*XLEN-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = op;
                    rd_d   = rd_from_idex;
                    neg1_d = neg1;
                    neg2_d = neg2;
                    cnt_d  = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end
`ifdef ZCRV_MDU_FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == MDU_ITER_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
        end
    end

    assign mdu_busy   = (state_q != S_IDLE);
    assign mdu_finish = (state_q == S_DONE);
    assign mdu_result = result_q;
    assign mdu_now_rd = rd_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: table of operations with hand-computed
// results and latencies, plus reject / flush / reset sequences.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

`ifdef ZCRV_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd = '0;
    logic        busy, finish;
    logic [31:0] result;
    logic [4:0]  now_rd;

    int n_vec = 0;
    int n_bad = 0;

    mdu_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_from_flushunit (flush),
        .mdu_start_from_idex  (start),
        .mdu_op_from_idex     (op),
        .rs1_data_from_idex   (a),
        .rs2_data_from_idex   (b),
        .rd_from_idex         (rd),
        .mdu_busy             (busy),
        .mdu_finish           (finish),
        .mdu_result           (result),
        .mdu_now_rd           (now_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns in cycle T+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] r);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        rd = r;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle T+k0; returns in the finish cycle.
    task automatic wait_finish(input int k0, output int lat,
                               output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = k0; k <= 80; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (finish === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic count_finish(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (finish === 1'b1) cnt++;
            tick();
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int lat;
        logic bok;
        issue(v.op, v.a, v.b, v.rd);
        wait_finish(1, lat, bok);
        chk($sformatf("v%0d_res", i), result, v.exp);
        chk($sformatf("v%0d_rd", i), 32'(now_rd), 32'(v.rd));
        chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
        tick();
        chk($sformatf("v%0d_post", i), {30'd0, busy, finish}, 32'd0);
        chk($sformatf("v%0d_hold", i), result, v.exp);
    endtask

    initial begin
        int lat;
        int cnt;
        logic bok;

        vt.push_back('{ZCRV_MDU_MUL,    32'd7,        32'hFFFFFFFD, 5'd4,  32'hFFFFFFEB, MUL_LAT});
        vt.push_back('{ZCRV_MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, MUL_LAT});
        vt.push_back('{ZCRV_MDU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000, MUL_LAT});
        vt.push_back('{ZCRV_MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, MUL_LAT});
        vt.push_back('{ZCRV_MDU_MULHU,  32'h80000000, 32'd2,        5'd8,  32'h00000001, MUL_LAT});
        vt.push_back('{ZCRV_MDU_DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, DIV_LAT});
        vt.push_back('{ZCRV_MDU_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, DIV_LAT});
        vt.push_back('{ZCRV_MDU_DIVU,   32'd100,      32'd7,        5'd11, 32'd14,       DIV_LAT});
        vt.push_back('{ZCRV_MDU_REMU,   32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT});
        vt.push_back('{ZCRV_MDU_DIV,    32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, DIV_LAT});
        vt.push_back('{ZCRV_MDU_REM,    32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        DIV_LAT});
        vt.push_back('{ZCRV_MDU_REMU,   32'hFFFFFFFF, 32'h10,       5'd0,  32'd15,       DIV_LAT});
        vt.push_back('{ZCRV_MDU_DIVU,   32'hFFFFFFFF, 32'd1,        5'd15, 32'hFFFFFFFF, DIV_LAT});
        vt.push_back('{ZCRV_MDU_DIV,    32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1});
        vt.push_back('{ZCRV_MDU_REMU,   32'd5,        32'd0,        5'd17, 32'd5,        1});
        vt.push_back('{ZCRV_MDU_REM,    32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFB, 1});
        vt.push_back('{ZCRV_MDU_DIVU,   32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 1});
        vt.push_back('{ZCRV_MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h80000000, 1});
        vt.push_back('{ZCRV_MDU_REM,    32'h80000000, 32'hFFFFFFFF, 5'd21, 32'd0,        1});

        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_finish", 32'(finish), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd", 32'(now_rd), 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(i, vt[i]);
        end

        // Start while busy is ignored.
        issue(ZCRV_MDU_DIVU, 32'd100, 32'd7, 5'd3);
        tick();
        tick();
        tick();
        tick();
        start = 1'b1;
        op = ZCRV_MDU_MUL;
        a = 32'd7;
        b = 32'hFFFFFFFD;
        rd = 5'd9;
        tick();
        start = 1'b0;
        wait_finish(6, lat, bok);
        chk("busy_rej_lat", 32'(lat), 32'd34);
        chk("busy_rej_res", result, 32'd14);
        chk("busy_rej_rd", 32'(now_rd), 32'd3);
        tick();
        count_finish(40, cnt);
        chk("busy_rej_nofin", 32'(cnt), 32'd0);

        // Start with flush high is not accepted.
        start = 1'b1;
        flush = 1'b1;
        op = ZCRV_MDU_DIVU;
        a = 32'd50;
        b = 32'd5;
        rd = 5'd22;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        count_finish(40, cnt);
        chk("flush_nofin", 32'(cnt), 32'd0);
        chk("flush_rd", 32'(now_rd), 32'd3);

        // Reset in the middle of a divide.
        issue(ZCRV_MDU_DIVU, 32'd1000, 32'd3, 5'd23);
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_result", result, 32'd0);
        chk("rstmid_rd", 32'(now_rd), 32'd0);
        count_finish(40, cnt);
        chk("rstmid_nofin", 32'(cnt), 32'd0);

        // Unit is usable again after the reset.
        issue(ZCRV_MDU_DIVU, 32'd1000, 32'd3, 5'd24);
        wait_finish(1, lat, bok);
        chk("after_rst_res", result, 32'd333);
        chk("after_rst_lat", 32'(lat), 32'd34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
